// File: rtl/ysyx_23060332_ifu.sv
// Instruction fetch unit: takes a PC from the core, fetches one instruction
// word over a req/gnt/rvalid bus and hands it to the core with valid/ready.
// At most one fetch is in flight. Misaligned PCs and bus timeouts are reported
// through fetch_err_o together with a NOP. Flushes discard the current fetch.
module ysyx_23060332_ifu #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INST_W  = 32,
  parameter int unsigned TMO_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              pc_valid_i,
  output logic              pc_ready_o,
  input  logic              flush_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [INST_W-1:0] imem_rdata_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic              fetch_err_o
);

  localparam int unsigned TMR_W = $clog2(TMO_CYC + 1);
  localparam logic [INST_W-1:0] NOP = INST_W'(32'h0000_0013);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e            state_q;
  logic [TMR_W-1:0]  timer_q;
  logic [TMR_W-1:0]  timer_d;
  logic              drop_q;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [INST_W-1:0] inst_q;
  logic              valid_q;
  logic              err_q;
  logic              tmo_hit;

  // Timeout fires in the WAIT cycle where the timer already holds TMO_CYC-1;
  // the timer never counts beyond that value, so it saturates there.
  always_comb begin
    tmo_hit = (timer_q == TMR_W'(TMO_CYC - 1));
    timer_d = tmo_hit ? timer_q : timer_q + TMR_W'(1);
  end

  // Fetch FSM with registered bus and core-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      drop_q  <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      inst_q  <= NOP;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pc_valid_i && !flush_i) begin
            addr_q <= pc_i;
            drop_q <= 1'b0;
            if (pc_i[1:0] != 2'b00) begin
              state_q <= S_HOLD;
              valid_q <= 1'b1;
              err_q   <= 1'b1;
              inst_q  <= NOP;
            end else begin
              state_q <= S_REQ;
              req_q   <= 1'b1;
            end
          end
        end
        S_REQ: begin
          // A request already on the bus cannot be withdrawn; a flush only
          // marks the eventual response for discarding.
          if (flush_i) drop_q <= 1'b1;
          if (imem_gnt_i) begin
            req_q   <= 1'b0;
            timer_q <= '0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (flush_i) drop_q <= 1'b1;
          if (imem_rvalid_i || tmo_hit) begin
            drop_q <= 1'b0;
            if (drop_q || flush_i) begin
              state_q <= S_IDLE;
            end else begin
              state_q <= S_HOLD;
              valid_q <= 1'b1;
              err_q   <= !imem_rvalid_i;
              inst_q  <= imem_rvalid_i ? imem_rdata_i : NOP;
            end
          end else begin
            timer_q <= timer_d;
          end
        end
        S_HOLD: begin
          if (flush_i || inst_ready_i) begin
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pc_ready_o   = (state_q == S_IDLE);
  assign imem_req_o   = req_q;
  assign imem_addr_o  = addr_q;
  assign inst_addr_o  = addr_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = valid_q;
  assign fetch_err_o  = err_q;

endmodule

// File: tb/tb_ysyx_23060332_ifu.sv
// Directed bench for ysyx_23060332_ifu: stimulus pushes expected instructions
// into a scoreboard queue, a monitor pops and compares on each core handshake.
module tb_ysyx_23060332_ifu;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        pc_valid;
  logic        pc_ready;
  logic        flush;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        inst_valid;
  logic        inst_ready;
  logic        err;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  logic early;

  ysyx_23060332_ifu #(.ADDR_W(32), .INST_W(32), .TMO_CYC(255)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc),
    .pc_valid_i   (pc_valid),
    .pc_ready_o   (pc_ready),
    .flush_i      (flush),
    .imem_req_o   (req),
    .imem_addr_o  (addr),
    .imem_gnt_i   (gnt),
    .imem_rvalid_i(rvalid),
    .imem_rdata_i (rdata),
    .inst_o       (inst),
    .inst_addr_o  (inst_addr),
    .inst_valid_o (inst_valid),
    .inst_ready_i (inst_ready),
    .fetch_err_o  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic pe();
    @(posedge clk);
    #1;
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_inst"},  inst,       32'h0000_0013);
    chk({tag, "_iaddr"}, inst_addr,  32'h0);
    chk({tag, "_addr"},  addr,       32'h0);
    chk({tag, "_req"},   req,        32'h0);
    chk({tag, "_valid"}, inst_valid, 32'h0);
    chk({tag, "_err"},   err,        32'h0);
    chk({tag, "_pcrdy"}, pc_ready,   32'h1);
  endtask

  // Monitor: every accepted instruction must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && inst_valid && inst_ready && !flush) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL mon_unexpected: got inst %h addr %h, want no instruction", inst, inst_addr);
      end else begin
        e = q.pop_front();
        chk("mon_inst", inst, e.inst);
        chk("mon_addr", inst_addr, e.addr);
        chk("mon_err", err, e.err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; pc = '0; pc_valid = 0; flush = 0; gnt = 0; rvalid = 0; rdata = '0; inst_ready = 0;
    pe(); pe();
    nx(); chk_reset("rst");
    pe(); rst = 0;

    // T1: zero-wait fetch, valid at cycle 3
    pc = 32'h8000_0000; pc_valid = 1;
    nx(); chk("t1_pcrdy_c0", pc_ready, 1);
    pe(); pc_valid = 0; gnt = 1;
    nx(); chk("t1_req_c1", req, 1); chk("t1_addr_c1", addr, 32'h8000_0000);
    pe(); gnt = 0; rvalid = 1; rdata = 32'h0010_0093;
    q.push_back('{inst: 32'h0010_0093, addr: 32'h8000_0000, err: 1'b0});
    nx(); chk("t1_valid_c2", inst_valid, 0); chk("t1_req_c2", req, 0);
    pe(); rvalid = 0; inst_ready = 1;
    nx(); chk("t1_valid_c3", inst_valid, 1);
    pe(); inst_ready = 0;
    nx(); chk("t1_valid_c4", inst_valid, 0); chk("t1_pcrdy_c4", pc_ready, 1);
    pe();

    // T2: gnt delayed 3 cycles, rvalid 2 cycles after gnt
    pc = 32'h8000_0010; pc_valid = 1;
    pe(); pc_valid = 0;
    for (int i = 0; i < 4; i++) begin
      gnt = (i == 3);
      nx(); chk("t2_req_hold", req, 1); chk("t2_addr_hold", addr, 32'h8000_0010);
      pe();
    end
    gnt = 0;
    nx(); chk("t2_req_wait", req, 0); chk("t2_valid_wait", inst_valid, 0);
    pe(); rvalid = 1; rdata = 32'h0020_8113;
    q.push_back('{inst: 32'h0020_8113, addr: 32'h8000_0010, err: 1'b0});
    pe(); rvalid = 0; inst_ready = 1;
    nx(); chk("t2_valid", inst_valid, 1);
    pe(); inst_ready = 0;

    // T3 + HOLD stall: misaligned PC, outputs stable for 5 cycles
    pc = 32'h8000_0002; pc_valid = 1;
    q.push_back('{inst: 32'h0000_0013, addr: 32'h8000_0002, err: 1'b1});
    pe(); pc_valid = 0;
    for (int i = 0; i < 5; i++) begin
      nx();
      chk("t3_req", req, 0); chk("t3_valid", inst_valid, 1); chk("t3_err", err, 1);
      chk("t3_inst", inst, 32'h0000_0013); chk("t3_iaddr", inst_addr, 32'h8000_0002);
      chk("t3_pcrdy", pc_ready, 0);
      pe();
    end
    inst_ready = 1;
    pe(); inst_ready = 0;

    // T4: flush in REQ before gnt, response dropped
    inst_ready = 1;
    pc = 32'h8000_0020; pc_valid = 1;
    pe(); pc_valid = 0; flush = 1;
    nx(); chk("t4_req_flush", req, 1);
    pe(); flush = 0;
    nx(); chk("t4_req_held", req, 1);
    pe(); gnt = 1;
    nx(); chk("t4_req_gnt", req, 1); chk("t4_addr", addr, 32'h8000_0020);
    pe(); gnt = 0; rvalid = 1; rdata = 32'hdead_beef;
    nx(); chk("t4_valid_rv", inst_valid, 0);
    pe(); rvalid = 0;
    nx(); chk("t4_pcrdy", pc_ready, 1); chk("t4_valid", inst_valid, 0);
    pe();

    // T4b: flush together with inst_ready in HOLD discards, no handshake
    pc = 32'h8000_0040; pc_valid = 1;
    pe(); pc_valid = 0; gnt = 1;
    pe(); gnt = 0; rvalid = 1; rdata = 32'h1111_1111;
    pe(); rvalid = 0; flush = 1;
    nx(); chk("t4b_valid_hold", inst_valid, 1);
    pe(); flush = 0;
    nx(); chk("t4b_valid_after", inst_valid, 0); chk("t4b_pcrdy", pc_ready, 1);
    pe(); inst_ready = 0;

    // T4c: flush in IDLE ignores pc_valid
    pc = 32'h8000_0050; pc_valid = 1; flush = 1;
    pe(); pc_valid = 0; flush = 0;
    nx(); chk("t4c_pcrdy", pc_ready, 1); chk("t4c_req", req, 0);
    pe();

    // T5: timeout after 255 WAIT cycles without rvalid
    pc = 32'h8000_0030; pc_valid = 1;
    pe(); pc_valid = 0; gnt = 1;
    pe(); gnt = 0;
    early = 0;
    for (int i = 0; i < 254; i++) begin
      nx(); if (inst_valid) early = 1;
      pe();
    end
    chk("t5_no_early", early, 0);
    q.push_back('{inst: 32'h0000_0013, addr: 32'h8000_0030, err: 1'b1});
    nx(); chk("t5_valid_last_wait", inst_valid, 0);
    pe(); inst_ready = 1;
    nx(); chk("t5_valid", inst_valid, 1);
    pe(); inst_ready = 0;

    // T5b: rvalid in the final WAIT cycle beats the timeout
    pc = 32'h8000_0034; pc_valid = 1;
    pe(); pc_valid = 0; gnt = 1;
    pe(); gnt = 0;
    for (int i = 0; i < 254; i++) pe();
    rvalid = 1; rdata = 32'h0050_0293;
    q.push_back('{inst: 32'h0050_0293, addr: 32'h8000_0034, err: 1'b0});
    pe(); rvalid = 0; inst_ready = 1;
    nx(); chk("t5b_valid", inst_valid, 1);
    pe(); inst_ready = 0;

    // T6: reset mid-WAIT, then a stray rvalid is ignored
    pc = 32'h8000_0060; pc_valid = 1;
    pe(); pc_valid = 0; gnt = 1;
    pe(); gnt = 0; rst = 1;
    pe(); rst = 0;
    nx(); chk_reset("t6");
    pe(); rvalid = 1; rdata = 32'h2222_2222;
    pe(); rvalid = 0;
    nx(); chk("t6_stray_valid", inst_valid, 0); chk("t6_stray_req", req, 0);
    pe();

    chk("sb_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
